// File: rtl/pingpong_trans_buf.sv
// pingpong_trans_buf: two-bank ping-pong transpose buffer.
// The writer fills one bank in row-major order while the reader drains the
// other bank in column-major order, so frames leave transposed.
// Optional feature macro: PPBUF_PASSTHRU_EN adds a trans_en input. trans_en
// selects, per frame, between the transposed read order and plain row-major
// pass-through.
module pingpong_trans_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 8,
    parameter int COLS       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef PPBUF_PASSTHRU_EN
    input  logic                  trans_en,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [1:0]            bank_full
);

    localparam int DEPTH      = ROWS * COLS;
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int R_W        = $clog2(ROWS);
    localparam int C_W        = $clog2(COLS);

    // Two single-port banks; full gating guarantees a bank is never written
    // and read in the same cycle.
    logic [DATA_WIDTH-1:0] mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] mem1 [DEPTH];

    logic                  wr_bank;
    logic                  rd_bank;
    logic [1:0]            bank_full_q;
    logic [1:0]            bank_full_nxt;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [R_W-1:0]        r_cnt;
    logic [C_W-1:0]        c_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic                  wr_fire;
    logic                  wr_last;
    logic                  rd_issue;
    logic                  rd_last;

    logic                  vld_p1;
    logic                  last_p1;
    logic [DATA_WIDTH-1:0] rd_data_p1;

    assign in_ready  = !bank_full_q[wr_bank];
    assign wr_fire   = in_valid && in_ready;
    assign wr_last   = (wr_cnt == ADDR_WIDTH'(DEPTH - 1));

    assign rd_issue  = bank_full_q[rd_bank] && (!vld_p1 || out_ready);
    assign rd_last   = (r_cnt == R_W'(ROWS - 1)) && (c_cnt == C_W'(COLS - 1));

`ifdef PPBUF_PASSTHRU_EN
    // Read-order mode captured with each bank on the first write of its frame.
    logic [1:0] trans_mode_q;

    // Latch trans_en per bank at the start of every frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trans_mode_q <= 2'b11;
        end else if (wr_fire && (wr_cnt == '0)) begin
            trans_mode_q[wr_bank] <= trans_en;
        end
    end

    // Transposed: r*COLS + c. Row-major: the running index c*ROWS + r.
    assign rd_addr = trans_mode_q[rd_bank] ? {r_cnt, c_cnt} : {c_cnt, r_cnt};
`else
    // r is the inner counter, so walking r first reads one column at a time.
    assign rd_addr = {r_cnt, c_cnt};
`endif

    // Full flags: set when a frame completes, cleared when its last read issues.
    always_comb begin
        bank_full_nxt = bank_full_q;
        if (wr_fire && wr_last) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
        if (rd_issue && rd_last) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
    end

    // Write pointer, bank select and full flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank     <= 1'b0;
            wr_cnt      <= '0;
            bank_full_q <= 2'b00;
        end else begin
            bank_full_q <= bank_full_nxt;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_cnt  <= wr_cnt + 1'b1;
                end
            end
        end
    end

    // Bank write port; RAM contents are deliberately left uncleared.
    always_ff @(posedge clk) begin
        if (wr_fire && !wr_bank) begin
            mem0[wr_cnt] <= in_data;
        end
        if (wr_fire && wr_bank) begin
            mem1[wr_cnt] <= in_data;
        end
    end

    // Read counters: r inner, c outer, bank toggles after the final address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank <= 1'b0;
            r_cnt   <= '0;
            c_cnt   <= '0;
        end else if (rd_issue) begin
            if (rd_last) begin
                r_cnt   <= '0;
                c_cnt   <= '0;
                rd_bank <= !rd_bank;
            end else if (r_cnt == R_W'(ROWS - 1)) begin
                r_cnt   <= '0;
                c_cnt   <= c_cnt + 1'b1;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    // ---- stage p1: RAM read register doubles as the output register ----
    // Holds its value whenever no read is issued (backpressure or idle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            rd_data_p1 <= '0;
        end else if (rd_issue) begin
            vld_p1     <= 1'b1;
            last_p1    <= rd_last;
            rd_data_p1 <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
        end else if (out_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_last  = last_p1;
    assign out_data  = rd_data_p1;
    assign bank_full = bank_full_q;

endmodule

// File: tb/tb_pingpong_trans_buf.sv
// Scoreboard bench for pingpong_trans_buf with 4x4 frames.
module tb_pingpong_trans_buf;

    localparam int DW = 32;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int N  = R * C;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    bank_full;
`ifdef PPBUF_PASSTHRU_EN
    logic          trans_en;
`endif

    pingpong_trans_buf #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PPBUF_PASSTHRU_EN
        .trans_en  (trans_en),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .bank_full (bank_full)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    int          stalls = 0;
    int          nacc = 0;
    logic [DW:0] sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue the expected output sequence of one frame: {last, data}.
    task automatic push_frame(input int base, input bit trans);
        for (int k = 0; k < N; k++) begin
            int v;
            if (trans) v = base + (k % R) * C + (k / R);
            else       v = base + k;
            sb.push_back({(k == N - 1), DW'(v)});
        end
    endtask

    // Present one element and wait (bounded) until it is accepted.
    // Entered and left at posedge+1.
    task automatic write_elem(input int d);
        bit acc;
        in_valid = 1'b1;
        in_data  = DW'(d);
        acc = 1'b0;
        for (int t = 0; t < 1000 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
        end
        check("wr_accept", acc, 1);
        if (acc) nacc++;
    endtask

    task automatic write_frame(input int base);
        for (int i = 0; i < N; i++) write_elem(base + i);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
        check("drain_left", sb.size(), 0);
        repeat (3) @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_bank_full", bank_full, 2'b00);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every output handshake; check hold under stall.
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) check("hold_stable", {out_valid, out_data}, {1'b1, hold_data});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_out: got %0h with no element expected", out_data);
                end else begin
                    logic [DW:0] e;
                    e = sb.pop_front();
                    check("out_elem", {out_last, out_data}, e);
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit   seen;
        bit   found;
        logic prev_rdy;
        int   gaps;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef PPBUF_PASSTHRU_EN
        trans_en = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last",  out_last,  0);
        check("rst_out_data",  out_data,  0);
        check("rst_bank_full", bank_full, 2'b00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frame, consumer always ready; latency and transposed order.
        out_ready = 1'b1;
        push_frame(0, 1);
        write_frame(0);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_valid_t1", out_valid, 0);
        check("lat_full_t1",  bank_full, 2'b01);
        @(negedge clk);
        check("lat_valid_t2", out_valid, 1);
        check("lat_data_t2",  out_data,  0);
        wait_drain();

        // Three frames against a stalled consumer, then random drain.
        out_ready = 1'b0;
        nacc = 0;
        fork
            begin
                push_frame(0, 1);  write_frame(0);
                push_frame(16, 1); write_frame(16);
                push_frame(32, 1); write_frame(32);
                in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 200 && nacc < 32; t++) @(negedge clk);
                repeat (2) @(negedge clk);
                check("full_in_ready",  in_ready,  0);
                check("full_bank_full", bank_full, 2'b11);
                check("full_out_valid", out_valid, 1);
                check("full_out_data",  out_data,  0);
                seen = 1'b0;
                prev_rdy = in_ready;
                for (int t = 0; t < 400 && !seen; t++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (out_valid && out_last) seen = 1'b1;
                    else prev_rdy = in_ready;
                end
                check("f0_last_seen",      seen,     1);
                check("in_ready_pre_last", prev_rdy, 0);
                check("in_ready_post",     in_ready, 1);
                for (int t = 0; t < 2000 && (nacc < 48 || sb.size() != 0); t++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("three_accepts", nacc, 48);
        wait_drain();

        // Four frames streamed continuously with both sides ready.
        stalls = 0;
        gaps = 0;
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    push_frame(1000 + 16 * f, 1);
                    write_frame(1000 + 16 * f);
                end
                in_valid = 1'b0;
            end
            begin
                found = 1'b0;
                for (int t = 0; t < 100 && !found; t++) begin
                    @(negedge clk);
                    found = out_valid;
                end
                check("stream_first", found, 1);
                for (int i = 1; i < 4 * N; i++) begin
                    @(negedge clk);
                    if (!out_valid) gaps++;
                end
            end
        join
        check("stream_stalls", stalls, 0);
        check("stream_gaps",   gaps,   0);
        wait_drain();

        // Reset while writing (wr_cnt=7) and while reading.
        push_frame(200, 1);
        write_frame(200);
        for (int i = 0; i < 7; i++) write_elem(300 + i);
        in_valid = 1'b0;
        check("pre_rst_reading", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_in_ready",  in_ready,  1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_last",  out_last,  0);
        check("mid_rst_out_data",  out_data,  0);
        check("mid_rst_bank_full", bank_full, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_frame(100, 1);
        write_frame(100);
        in_valid = 1'b0;
        wait_drain();

`ifdef PPBUF_PASSTHRU_EN
        // Pass-through frame followed by a transposed frame.
        trans_en = 1'b0;
        push_frame(0, 0);
        write_frame(0);
        trans_en = 1'b1;
        push_frame(16, 1);
        write_frame(16);
        in_valid = 1'b0;
        wait_drain();
`endif

        check("sb_empty_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
